// File: rtl/shift_arbiter_if.sv
// Request/result handshake bundle between the two shift requesters, the
// result consumer and shift_arbiter.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic [1:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic [1:0]  req1_op;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_op,
    output req1_valid, req1_data, req1_amt, req1_op,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_op,
    input  req1_valid, req1_data, req1_amt, req1_op,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and sequencer for the shared barrel shifter.
// The SHIFT_ARB_STATS_EN macro adds the grant_cnt0/grant_cnt1 counters.
module shift_arbiter #(
  parameter int unsigned CNT_W     = 16,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  shift_arbiter_if.slave bus,
  output logic [31:0] sh_in_data,
  output logic [31:0] sh_shamt_32,
  output logic [1:0]  sh_func,
  input  logic [31:0] sh_out_data
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        prio_q;
  logic [31:0] res_data_q;
  logic        res_id_q;

  logic        can_accept;
  logic        gnt_vld;
  logic        gnt_id;
  logic [31:0] gnt_data;
  logic [4:0]  gnt_amt;
  logic [1:0]  gnt_op;

  // Grant selection; nothing is granted while in reset or while blocked.
  always_comb begin
    can_accept = !rst && ((state_q == EMPTY) || bus.res_ready);
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    if (can_accept) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (bus.req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    gnt_data = gnt_id ? bus.req1_data : bus.req0_data;
    gnt_amt  = gnt_id ? bus.req1_amt  : bus.req0_amt;
    gnt_op   = gnt_id ? bus.req1_op   : bus.req0_op;
  end

  // Next state, ready outputs and shifter drive.
  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    sh_in_data     = 32'd0;
    sh_shamt_32    = 32'd0;
    sh_func        = 2'd0;

    if (gnt_vld) begin
      bus.req0_ready = !gnt_id;
      bus.req1_ready = gnt_id;
      sh_in_data     = gnt_data;
      sh_func        = gnt_op;
      // Rotates take the amount in the low bits, shifts in bits 10:6.
      if (gnt_op == 2'd0) begin
        sh_shamt_32 = {27'd0, gnt_amt};
      end else begin
        sh_shamt_32 = {21'd0, gnt_amt, 6'd0};
      end
    end

    case (state_q)
      EMPTY: begin
        if (gnt_vld) state_d = FULL;
      end
      FULL: begin
        if (gnt_vld)            state_d = FULL;
        else if (bus.res_ready) state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      prio_q     <= PRIO_INIT;
      res_data_q <= 32'd0;
      res_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        res_data_q <= sh_out_data;
        res_id_q   <= gnt_id;
        prio_q     <= ~gnt_id;
      end
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Accepted-request counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (gnt_vld) begin
      if (gnt_id) cnt1_q <= cnt1_q + CNT_W'(1);
      else        cnt0_q <= cnt0_q + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
